// File: rtl/com_pkg.sv
// Shared definitions for the inter-board COM link (receive and transmit sides).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package com_pkg;

  typedef enum logic [2:0] {
    COM_IDLE,
    COM_RECV,
    COM_DONE,
    COM_ACK,
    COM_RELEASE
  } com_rx_state_t;

  localparam int COM_BEATS  = 6;
  localparam int COM_BUS_W  = 6;
  localparam int COM_WORD_W = 32;

  // Full frame as assembled by the receiver: all six beats side by side.
  localparam int COM_FRAME_W = COM_BEATS * COM_BUS_W;

  // Position of the parity bit inside the assembled frame (beat 5, bit 2).
  localparam int COM_PAR_BIT = COM_WORD_W;

  // Bus values driven back to the transmitter during turnaround.
  localparam logic [COM_BUS_W-1:0] COM_ACK_CODE = 6'b000001;
  localparam logic [COM_BUS_W-1:0] COM_REL_CODE = 6'b000000;

  // Even parity bit for a data word: the bit that makes the total count of ones even.
  function automatic logic com_even_parity(input logic [COM_WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/com_sync.sv
// Parameterized-width 2-FF synchronizer for signals arriving from another clock domain.
// Latency: 2 clk cycles from input change to output.
// Backpressure: none; free-running every cycle.
module com_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  // Next-state: plain two-stage shift.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/de2115_com_rx.sv
// COM link receiver: deserializes 6-beat frames from com_channel into 32-bit words and acks them.
// Latency: data_valid and ack rise 1 cycle after DONE sees com_req low and a free output register.
// Backpressure: a full output register parks the FSM in DONE without acking, stalling the sender.
// Optional feature: COM_PARITY_EN enables even-parity checking on beat 5 bit 2.
module de2115_com_rx
  import com_pkg::*;
#(
  parameter int ACK_CYCLES = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [5:0]  com_channel,
  input  logic        com_clk,
  input  logic        com_req,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        frame_err,
  output logic        parity_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ACK_W = $clog2(ACK_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_CYCLES - 1);
  localparam logic [2:0]       BEAT_LAST = 3'(COM_BEATS - 1);

  // Synchronized copies of the transmitter-side signals.
  logic                 com_clk_s;
  logic                 com_req_s;
  logic [COM_BUS_W-1:0] chan_s;

  com_sync #(.W(1)) u_sync_clk (
    .clk   (clk),
    .rst_n (rst),
    .d     (com_clk),
    .q     (com_clk_s)
  );

  com_sync #(.W(1)) u_sync_req (
    .clk   (clk),
    .rst_n (rst),
    .d     (com_req),
    .q     (com_req_s)
  );

  com_sync #(.W(COM_BUS_W)) u_sync_chan (
    .clk   (clk),
    .rst_n (rst),
    .d     (com_channel),
    .q     (chan_s)
  );

  com_rx_state_t          state_d, state_q;
  logic [2:0]             beat_cnt_d, beat_cnt_q;
  logic [COM_FRAME_W-1:0] shift_d, shift_q;
  logic [TMO_W-1:0]       tmo_cnt_d, tmo_cnt_q;
  logic [ACK_W-1:0]       ack_cnt_d, ack_cnt_q;
  logic                   oe_d, oe_q;
  logic [COM_BUS_W-1:0]   drv_d, drv_q;
  logic [COM_WORD_W-1:0]  data_d, data_q;
  logic                   valid_d, valid_q;
  logic                   frame_err_d, frame_err_q;
  logic                   parity_err_d, parity_err_q;
  logic                   clk_prev_d, clk_prev_q;

  logic                   beat;
  logic                   out_free;
  logic                   par_ok;
  logic [COM_WORD_W-1:0]  rx_word;

  // A beat is the first cycle the synced strobe is seen high.
  assign beat     = com_clk_s & ~clk_prev_q;
  assign out_free = ~valid_q | data_ready;
  assign rx_word  = shift_q[COM_WORD_W-1:0];

`ifdef COM_PARITY_EN
  assign par_ok = (com_even_parity(rx_word) == shift_q[COM_PAR_BIT]);
  logic unused_frame_bits;
  assign unused_frame_bits = ^shift_q[COM_FRAME_W-1:COM_PAR_BIT+1];
`else
  // Beat 5 bits [5:2] carry nothing in this build; every complete frame is accepted.
  assign par_ok = 1'b1;
  logic unused_frame_bits;
  assign unused_frame_bits = ^shift_q[COM_FRAME_W-1:COM_WORD_W];
`endif

  // Next-state and output-register logic for the receive FSM.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    shift_d      = shift_q;
    tmo_cnt_d    = tmo_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    oe_d         = oe_q;
    drv_d        = drv_q;
    data_d       = data_q;
    valid_d      = valid_q & ~data_ready;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    clk_prev_d   = com_clk_s;

    case (state_q)
      COM_IDLE: begin
        oe_d = 1'b0;
        if (com_req_s) begin
          state_d    = COM_RECV;
          beat_cnt_d = '0;
          shift_d    = '0;
          tmo_cnt_d  = '0;
        end
      end

      COM_RECV: begin
        if (!com_req_s) begin
          state_d     = COM_IDLE;
          frame_err_d = 1'b1;
        end else if (beat) begin
          // LSB-first: each new beat enters at the top and earlier beats move down.
          shift_d    = {chan_s, shift_q[COM_FRAME_W-1:COM_BUS_W]};
          beat_cnt_d = beat_cnt_q + 3'd1;
          tmo_cnt_d  = '0;
          if (beat_cnt_q == BEAT_LAST) begin
            state_d = COM_DONE;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = COM_IDLE;
          frame_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      COM_DONE: begin
        // The sender must have released the bus before we turn it around.
        if (!com_req_s && out_free) begin
          oe_d = 1'b1;
          if (par_ok) begin
            data_d    = rx_word;
            valid_d   = 1'b1;
            state_d   = COM_ACK;
            drv_d     = COM_ACK_CODE;
            ack_cnt_d = '0;
          end else begin
            // Withhold the ack so the sender retries.
            parity_err_d = 1'b1;
            state_d      = COM_RELEASE;
            drv_d        = COM_REL_CODE;
          end
        end
      end

      COM_ACK: begin
        if (ack_cnt_q == ACK_LAST) begin
          state_d = COM_RELEASE;
          drv_d   = COM_REL_CODE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      COM_RELEASE: begin
        state_d = COM_IDLE;
        oe_d    = 1'b0;
        drv_d   = COM_REL_CODE;
      end

      default: begin
        state_d = COM_IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State registers; reset drops the bus drive immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= COM_IDLE;
      beat_cnt_q   <= '0;
      shift_q      <= '0;
      tmo_cnt_q    <= '0;
      ack_cnt_q    <= '0;
      oe_q         <= 1'b0;
      drv_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      clk_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      shift_q      <= shift_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      oe_q         <= oe_d;
      drv_q        <= drv_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      clk_prev_q   <= clk_prev_d;
    end
  end

  assign com_channel = oe_q ? drv_q : {COM_BUS_W{1'bz}};

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_de2115_com_rx.sv
// Directed bench for the COM link receiver.
// Latency: n/a (testbench).
// Backpressure: exercised through data_ready.
module tb_de2115_com_rx;

  logic        clk;
  logic        rst;
  logic        com_clk;
  logic        com_req;
  logic        data_ready;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        parity_err;
  logic [5:0]  tb_chan;
  logic        tb_oe;
  wire  [5:0]  com_channel;

  int checks;
  int errors;
  int mon_ferr;
  int mon_perr;
  int mon_ack;
  int mon_oe;
  int mon_valid;

  assign com_channel = tb_oe ? tb_chan : 6'bzzzzzz;

  de2115_com_rx #(
    .ACK_CYCLES (8),
    .TIMEOUT    (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .com_channel (com_channel),
    .com_clk     (com_clk),
    .com_req     (com_req),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running event counts sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_err)  mon_ferr  <= mon_ferr + 1;
    if (parity_err) mon_perr  <= mon_perr + 1;
    if (data_valid) mon_valid <= mon_valid + 1;
    if (dut.oe_q)   mon_oe    <= mon_oe + 1;
    if (dut.oe_q && com_channel == 6'b000001) mon_ack <= mon_ack + 1;
  end

  function automatic logic [3:0] good_top(input logic [31:0] w);
    return {3'b000, ^w};
  endfunction

  task automatic send_beat(input logic [5:0] v);
    tb_chan = v;
    repeat (4) @(negedge clk);
    com_clk = 1'b1;
    repeat (5) @(negedge clk);
    com_clk = 1'b0;
    @(negedge clk);
  endtask

  // top4 fills beat 5 bits [5:2]; nbeats < 6 gives a truncated frame.
  task automatic send_frame(input logic [31:0] w, input logic [3:0] top4, input int nbeats);
    logic [35:0] full;
    full    = {top4, w};
    com_req = 1'b1;
    tb_oe   = 1'b1;
    tb_chan = 6'h00;
    repeat (4) @(negedge clk);
    for (int k = 0; k < nbeats; k++) begin
      send_beat(full[k*6 +: 6]);
    end
    repeat (2) @(negedge clk);
    com_req = 1'b0;
    tb_oe   = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (data_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_oe_low(input int maxc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (!dut.oe_q) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_out: got %h expected 00000000", data_out);
    end
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_data_valid: got %b expected 0", data_valid);
    end
    checks++;
    if (frame_err !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_errs: got frame_err=%b parity_err=%b expected 0 0", frame_err, parity_err);
    end
    checks++;
    if (dut.oe_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_oe: got %b expected 0", dut.oe_q);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    bit          ok;
    bit   [11:0] valid_h;
    bit   [11:0] oe_h;
    bit   [11:0] ack_h;
    bit          rel_zero;
    logic [31:0] first_data;
    data_ready = 1'b1;
    send_frame(32'hDEADBEEF, good_top(32'hDEADBEEF), 6);
    wait_valid(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: got no data_valid expected data_valid within 50 cycles");
    end
    first_data = data_out;
    rel_zero   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      valid_h[i] = data_valid;
      oe_h[i]    = dut.oe_q;
      ack_h[i]   = (com_channel == 6'b000001);
      if (i == 8) rel_zero = (com_channel == 6'b000000);
      @(negedge clk);
    end
    checks++;
    if (first_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_data: got %h expected deadbeef", first_data);
    end
    checks++;
    if (valid_h !== 12'h001) begin
      errors++;
      $display("FAIL single_valid_pulse: got %b expected 000000000001", valid_h);
    end
    checks++;
    if (oe_h !== 12'h1FF) begin
      errors++;
      $display("FAIL single_oe_window: got %b expected 000111111111", oe_h);
    end
    checks++;
    if (ack_h[8:0] !== 9'h0FF) begin
      errors++;
      $display("FAIL single_ack_len: got %b expected 011111111", ack_h[8:0]);
    end
    checks++;
    if (!rel_zero) begin
      errors++;
      $display("FAIL single_release: got bus %b expected 000000", com_channel);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int a0;
    data_ready = 1'b0;
    send_frame(32'h1, good_top(32'h1), 6);
    wait_valid(50, ok);
    checks++;
    if (!ok || data_out !== 32'h1) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b data=%h expected 1 00000001", ok, data_out);
    end
    wait_oe_low(40, ok);
    a0 = mon_ack;
    send_frame(32'h2, good_top(32'h2), 6);
    repeat (20) @(negedge clk);
    checks++;
    if (data_out !== 32'h1 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: got valid=%b data=%h expected 1 00000001", data_valid, data_out);
    end
    checks++;
    if (dut.oe_q !== 1'b0 || mon_ack != a0) begin
      errors++;
      $display("FAIL b2b_no_ack: got oe=%b ack_cycles=%0d expected 0 0", dut.oe_q, mon_ack - a0);
    end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    checks++;
    if (data_out !== 32'h2 || data_valid !== 1'b1 || com_channel !== 6'b000001) begin
      errors++;
      $display("FAIL b2b_swap: got valid=%b data=%h bus=%b expected 1 00000002 000001",
               data_valid, data_out, com_channel);
    end
    wait_oe_low(40, ok);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 32'h2) begin
      errors++;
      $display("FAIL b2b_second_held: got valid=%b data=%h expected 1 00000002", data_valid, data_out);
    end
    data_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got valid=%b expected 0", data_valid);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_abort();
    int f0;
    int v0;
    int o0;
    data_ready = 1'b1;
    f0 = mon_ferr;
    v0 = mon_valid;
    o0 = mon_oe;
    send_frame(32'h0BADF00D, 4'h0, 3);
    repeat (20) @(negedge clk);
    checks++;
    if (mon_ferr - f0 != 1) begin
      errors++;
      $display("FAIL abort_frame_err: got %0d pulses expected 1", mon_ferr - f0);
    end
    checks++;
    if (mon_valid != v0) begin
      errors++;
      $display("FAIL abort_valid: got %0d valid cycles expected 0", mon_valid - v0);
    end
    checks++;
    if (mon_oe != o0) begin
      errors++;
      $display("FAIL abort_bus: got %0d driven cycles expected 0", mon_oe - o0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    data_ready = 1'b1;
    tb_chan    = 6'h00;
    tb_oe      = 1'b1;
    com_req    = 1'b1;
    n          = 0;
    ok         = 1'b0;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (frame_err) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
    com_req = 1'b0;
    tb_oe   = 1'b0;
    checks++;
    if (!ok || n < 1020 || n > 1032) begin
      errors++;
      $display("FAIL timeout_abort: got frame_err after %0d cycles (seen=%b) expected about 1027", n, ok);
    end
    repeat (20) @(negedge clk);
    send_frame(32'hA5A5A5A5, good_top(32'hA5A5A5A5), 6);
    wait_valid(50, ok);
    checks++;
    if (!ok || data_out !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL timeout_recover: got valid=%b data=%h expected 1 a5a5a5a5", ok, data_out);
    end
    wait_oe_low(40, ok);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_ack();
    bit ok;
    data_ready = 1'b0;
    send_frame(32'h12345678, good_top(32'h12345678), 6);
    wait_valid(50, ok);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (!ok || dut.oe_q !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack: got seen=%b oe=%b valid=%b expected 1 0 0", ok, dut.oe_q, data_valid);
    end
    repeat (3) @(negedge clk);
    rst        = 1'b1;
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(32'hCAFEF00D, good_top(32'hCAFEF00D), 6);
    wait_valid(50, ok);
    checks++;
    if (!ok || data_out !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rst_recover: got valid=%b data=%h expected 1 cafef00d", ok, data_out);
    end
    wait_oe_low(40, ok);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_parity();
    bit ok;
    int p0;
    int v0;
    int a0;
    data_ready = 1'b1;
`ifdef COM_PARITY_EN
    p0 = mon_perr;
    v0 = mon_valid;
    a0 = mon_ack;
    send_frame(32'h00000001, 4'b0000, 6);
    repeat (30) @(negedge clk);
    checks++;
    if (mon_perr - p0 != 1) begin
      errors++;
      $display("FAIL parity_bad_pulse: got %0d pulses expected 1", mon_perr - p0);
    end
    checks++;
    if (mon_valid != v0 || mon_ack != a0) begin
      errors++;
      $display("FAIL parity_bad_drop: got valid=%0d ack=%0d cycles expected 0 0", mon_valid - v0, mon_ack - a0);
    end
    p0 = mon_perr;
    send_frame(32'h00000001, 4'b0001, 6);
`else
    // Reserved bits set and parity bit wrong: must still be accepted.
    p0 = mon_perr;
    v0 = mon_valid;
    a0 = mon_ack;
    send_frame(32'h00000001, 4'b1010, 6);
`endif
    wait_valid(50, ok);
    checks++;
    if (!ok || data_out !== 32'h00000001) begin
      errors++;
      $display("FAIL parity_accept: got valid=%b data=%h expected 1 00000001", ok, data_out);
    end
    wait_oe_low(40, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (mon_perr != p0) begin
      errors++;
      $display("FAIL parity_good_no_err: got %0d pulses expected 0", mon_perr - p0);
    end
`ifndef COM_PARITY_EN
    checks++;
    if (mon_valid - v0 != 1 || mon_ack - a0 != 8) begin
      errors++;
      $display("FAIL parity_ignored: got valid=%0d ack=%0d cycles expected 1 8", mon_valid - v0, mon_ack - a0);
    end
`endif
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    com_clk    = 1'b0;
    com_req    = 1'b0;
    data_ready = 1'b0;
    tb_chan    = 6'h00;
    tb_oe      = 1'b0;
    #1 rst     = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_reset_in_ack();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/de2115_com_rx.md
# de2115_com_rx

Receive end of the inter-board COM link, instantiated in the DE2-115 top level. It deserializes 32-bit words that the transmitting board sends over the 6-bit `com_channel` bus, using the `com_clk` strobe and the `com_req` frame signal. It presents each word on a valid/ready interface to local logic. It acknowledges each accepted word by driving the shared bus back during a turnaround window.

## Interface
- `ACK_CYCLES`, default 8: number of `clk` cycles that `com_channel[0]` is held high as acknowledge.
- `TIMEOUT`, default 1024: `clk` cycles allowed between `com_clk` rising edges inside a frame before the frame is aborted.
- `clk` input 1: single system clock. All logic runs in this domain.
- `rst` input 1: asynchronous, active-low reset.
- `com_channel` inout 6: shared data bus. Driven by the transmitter while `com_req` is high; driven by this block only in ACK/RELEASE.
- `com_clk` input 1: transmitter beat strobe. Asynchronous to `clk`.
- `com_req` input 1: frame-active flag from the transmitter. Asynchronous to `clk`.
- `data_out` output 32: received word.
- `data_valid` output 1: `data_out` holds an undelivered word.
- `data_ready` input 1: consumer accepts the word this cycle.
- `frame_err` output 1: one-cycle pulse when a frame is aborted.
- `parity_err` output 1: one-cycle pulse when a word is dropped for bad parity. Tied 0 without the macro.

## Operation
- Synchronizers:
  - `com_clk`, `com_req` and `com_channel[5:0]` each pass through 2-FF synchronizers.
  - A beat is the cycle where the synced `com_clk` is 1 and was 0 the previous cycle. The synced channel is captured on that cycle.
- Frame format: 6 beats, LSB first.
  - Beats 0–4 carry data bits [29:0], 6 bits per beat.
  - Beat 5 carries bits [31:30] on `com_channel[1:0]`; `com_channel[5:2]` is reserved.
- States:
  - IDLE: bus tri-stated. Synced `com_req`=1 → RECV with beat count 0 and shift register cleared.
  - RECV: each beat shifts in and increments the count. The 6th beat → DONE. Synced `com_req`=0 before the 6th beat → IDLE with a `frame_err` pulse. Timeout counter reaching `TIMEOUT` → IDLE with a `frame_err` pulse.
  - DONE: wait until synced `com_req`=0 AND the output register is free (`data_valid`=0, or `data_ready`=1 this cycle). Then load `data_out`, set `data_valid`, and go to ACK. Bus stays tri-stated.
  - ACK: drive `com_channel`=6'b000001 for `ACK_CYCLES` cycles, then go to RELEASE.
  - RELEASE: drive 6'b000000 for one cycle, then tri-state and go to IDLE.
- Output register:
  - `data_valid` clears on `data_valid & data_ready` unless a load happens the same cycle; a load wins and `data_valid` stays 1.
  - `data_out` is stable while `data_valid`=1 and `data_ready`=0.
- Back-pressure: the transmitter must not start a new frame until it has seen ack rise and fall. A full output register therefore stalls the link in DONE with no loss.
- Edges of `com_clk` seen in IDLE, DONE, ACK or RELEASE are ignored.

## Timing
- Reset values:
  - State IDLE, bus tri-stated (output enable 0).
  - `data_out`=0, `data_valid`=0, `frame_err`=0, `parity_err`=0.
  - All counters 0.
- Input requirements:
  - `com_clk` high and low phases must each be ≥4 `clk` cycles.
  - Channel data must be stable from 3 cycles before to 1 cycle after the `com_clk` rising edge.
- Latency:
  - The 6th raw `com_clk` edge is detected 2–3 cycles later.
  - `data_valid` rises 1 cycle after DONE sees both its conditions true.
  - Ack rises on the same cycle as `data_valid`.
- Reset asserted mid-frame or mid-ack: immediate return to IDLE. The partial word is discarded and the bus is released asynchronously.
- The timeout counter resets on every beat and on entry to RECV.

## Configuration
- `COM_PARITY_EN` defined:
  - Beat 5 bit 2 carries even parity over the 32 data bits.
  - On a mismatch, DONE does not load the word, pulses `parity_err`, and goes to RELEASE without acking.
  - The transmitter detects the missing ack and resends.
- `COM_PARITY_EN` undefined: bits [5:2] of beat 5 are ignored and `parity_err` is constant 0.

## Structure
- Package `com_pkg`:
  - State enum `com_rx_state_t`.
  - `COM_BEATS`=6, `COM_BUS_W`=6, `COM_WORD_W`=32.
  - Ack encoding constant, shared with the transmitter side.
- Sub-module `com_sync`: parameterized-width 2-FF synchronizer with async active-low reset. Used for `com_clk`, `com_req` and `com_channel`.
- Tri-state driving of `com_channel` stays inside this block via an output-enable register.

## Test plan
- Single frame carrying 32'hDEADBEEF, `data_ready`=1 → `data_out`=32'hDEADBEEF with a one-cycle `data_valid`; ack high for 8 cycles, then 1 cycle low, then Z.
- Two back-to-back frames (32'h1, 32'h2) with `data_ready`=0 → first word held, FSM parked in DONE with no ack. Raise `data_ready` → 32'h1 consumed, 32'h2 loaded the same cycle, ack follows.
- `com_req` dropped after 3 beats → `frame_err` pulses once, `data_valid` stays 0, bus never driven.
- `com_req` held high with no `com_clk` edge for 1024 cycles → `frame_err` pulse, return to IDLE. A following valid frame of 32'hA5A5A5A5 is received correctly.
- `rst` asserted during ACK → bus immediately Z, `data_valid`=0, then a clean receive after release.
- With `COM_PARITY_EN`: 32'h00000001 sent with parity bit 0 → `parity_err` pulse, no ack, `data_valid`=0. Resent with parity bit 1 → accepted.
